// File: rtl/arith_ctrl_pkg.sv
// Shared types, opcode constants and cycle-count helpers for the arith_ctrl sequencer.
package arith_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] FUN_ADD = 2'b00;
    localparam logic [1:0] FUN_SUB = 2'b01;
    localparam logic [1:0] FUN_MUL = 2'b10;
    localparam logic [1:0] FUN_DIV = 2'b11;

    localparam int MUL_CYC_DEF = 2;
    localparam int DIV_CYC_DEF = 4;

    // Wide enough to hold the largest (cycles - 1) load value with headroom.
    function automatic int cnt_w_of(input int mulCyc, input int divCyc);
        return $clog2((mulCyc > divCyc) ? mulCyc : divCyc) + 1;
    endfunction

    localparam int CNT_W = cnt_w_of(MUL_CYC_DEF, DIV_CYC_DEF);

    function automatic int cyc_of(input logic [1:0] fun, input int mulCyc, input int divCyc);
        case (fun)
            FUN_MUL: return mulCyc;
            FUN_DIV: return divCyc;
            default: return 1;
        endcase
    endfunction

endpackage

// File: rtl/arith_ctrl.sv
// Command/response sequencer for the combinational arithmetic unit with per-op settling time.
// Optional ARITH_CTRL_DIVZ_CHECK_EN short-circuits divide-by-zero into an error response.
module arith_ctrl
    import arith_ctrl_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int MUL_CYC = MUL_CYC_DEF,
    parameter int DIV_CYC = DIV_CYC_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_FUN,
    input  logic [WIDTH-1:0] CMD_OP_A,
    input  logic [WIDTH-1:0] CMD_OP_B,
    output logic             A_EN,
    output logic [1:0]       ALU_FUN,
    output logic [WIDTH-1:0] ALU_IN1,
    output logic [WIDTH-1:0] ALU_IN2,
    input  logic [WIDTH-1:0] ALU_OUT,
    input  logic             ALU_CARRY,
    input  logic             ALU_FLAG,
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic [WIDTH-1:0] RES_DATA,
    output logic             RES_CARRY,
    output logic             RES_ERR,
    output logic             BUSY
);

    localparam int CntW = cnt_w_of(MUL_CYC, DIV_CYC);

    state_t           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [CntW-1:0]  cntLoad_d;
    logic [1:0]       fun_q;
    logic [WIDTH-1:0] opA_q;
    logic [WIDTH-1:0] opB_q;
    logic [WIDTH-1:0] resData_q;
    logic             resCarry_q;
    logic             aEn_q;
    logic             resValid_q;
    logic             cmdReady_q;
    logic             busy_q;

    assign cntLoad_d = CntW'(cyc_of(CMD_FUN, MUL_CYC, DIV_CYC) - 1);

`ifdef ARITH_CTRL_DIVZ_CHECK_EN
    logic resErr_q;
    assign RES_ERR = resErr_q;
`else
    assign RES_ERR = 1'b0;
`endif

    // All handshake and enable outputs are registered alongside the state so they never glitch.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            fun_q      <= FUN_ADD;
            opA_q      <= '0;
            opB_q      <= '0;
            resData_q  <= '0;
            resCarry_q <= 1'b0;
            aEn_q      <= 1'b0;
            resValid_q <= 1'b0;
            cmdReady_q <= 1'b1;
            busy_q     <= 1'b0;
`ifdef ARITH_CTRL_DIVZ_CHECK_EN
            resErr_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (CMD_VALID && cmdReady_q) begin
                        fun_q      <= CMD_FUN;
                        opA_q      <= CMD_OP_A;
                        opB_q      <= CMD_OP_B;
                        cmdReady_q <= 1'b0;
                        busy_q     <= 1'b1;
`ifdef ARITH_CTRL_DIVZ_CHECK_EN
                        if (CMD_FUN == FUN_DIV && CMD_OP_B == '0) begin
                            resData_q  <= '1;
                            resCarry_q <= 1'b0;
                            resErr_q   <= 1'b1;
                            resValid_q <= 1'b1;
                            state_q    <= RESP;
                        end else begin
                            resErr_q   <= 1'b0;
                            cnt_q      <= cntLoad_d;
                            aEn_q      <= 1'b1;
                            state_q    <= EXEC;
                        end
`else
                        cnt_q   <= cntLoad_d;
                        aEn_q   <= 1'b1;
                        state_q <= EXEC;
`endif
                    end
                end
                EXEC: begin
                    if (cnt_q == '0) begin
                        resData_q  <= ALU_OUT;
                        resCarry_q <= (fun_q == FUN_ADD) && ALU_CARRY;
                        aEn_q      <= 1'b0;
                        resValid_q <= 1'b1;
                        state_q    <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (RES_READY) begin
                        resValid_q <= 1'b0;
                        cmdReady_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign CMD_READY = cmdReady_q;
    assign A_EN      = aEn_q;
    assign ALU_FUN   = fun_q;
    assign ALU_IN1   = opA_q;
    assign ALU_IN2   = opB_q;
    assign RES_VALID = resValid_q;
    assign RES_DATA  = resData_q;
    assign RES_CARRY = resCarry_q;
    assign BUSY      = busy_q;

    // The unit must report a valid result whenever it is enabled.
    aluFlagWhileEnabled: assert property (@(posedge CLK) disable iff (!RST) A_EN |-> ALU_FLAG);

endmodule

// File: tb/tb_arith_ctrl.sv
// Self-checking bench for arith_ctrl: behavioural arithmetic unit plus an expected-result scoreboard.
// Honours ARITH_CTRL_DIVZ_CHECK_EN to exercise the divide-by-zero error path.
module tb_arith_ctrl;

    localparam int WIDTH   = 16;
    localparam int MUL_CYC = 2;
    localparam int DIV_CYC = 4;

    typedef struct {
        logic [15:0] data;
        logic        carry;
        logic        err;
        int          execCyc;
        int          aEnCyc;
    } exp_t;

    logic        clock = 1'b0;
    logic        resetN;
    logic        cmdValid;
    logic        cmdReady;
    logic [1:0]  cmdFun;
    logic [15:0] cmdOpA;
    logic [15:0] cmdOpB;
    logic        aEn;
    logic [1:0]  aluFun;
    logic [15:0] aluIn1;
    logic [15:0] aluIn2;
    logic [15:0] aluOut;
    logic        aluCarry;
    logic        aluFlag;
    logic [31:0] aluProd;
    logic        resValid;
    logic        resReady;
    logic [15:0] resData;
    logic        resCarry;
    logic        resErr;
    logic        busy;

    exp_t sbQ[$];
    int   passCnt  = 0;
    int   failCnt  = 0;
    int   totalCnt = 0;

    always #5 clock = ~clock;

    arith_ctrl #(.WIDTH(WIDTH), .MUL_CYC(MUL_CYC), .DIV_CYC(DIV_CYC)) dut (
        .CLK(clock), .RST(resetN),
        .CMD_VALID(cmdValid), .CMD_READY(cmdReady), .CMD_FUN(cmdFun),
        .CMD_OP_A(cmdOpA), .CMD_OP_B(cmdOpB),
        .A_EN(aEn), .ALU_FUN(aluFun), .ALU_IN1(aluIn1), .ALU_IN2(aluIn2),
        .ALU_OUT(aluOut), .ALU_CARRY(aluCarry), .ALU_FLAG(aluFlag),
        .RES_VALID(resValid), .RES_READY(resReady), .RES_DATA(resData),
        .RES_CARRY(resCarry), .RES_ERR(resErr), .BUSY(busy)
    );

    // Behavioural arithmetic unit; carry also reflects borrow/overflow so the controller must mask it.
    always_comb begin
        aluOut   = '0;
        aluCarry = 1'b0;
        aluProd  = '0;
        aluFlag  = aEn;
        if (aEn) begin
            case (aluFun)
                2'b00: {aluCarry, aluOut} = {1'b0, aluIn1} + {1'b0, aluIn2};
                2'b01: {aluCarry, aluOut} = {1'b0, aluIn1} - {1'b0, aluIn2};
                2'b10: begin
                    aluProd  = {16'b0, aluIn1} * {16'b0, aluIn2};
                    aluOut   = aluProd[15:0];
                    aluCarry = |aluProd[31:16];
                end
                default: aluOut = (aluIn2 == '0) ? '1 : aluIn1 / aluIn2;
            endcase
        end
    end

    // Reference result and timing for one command, derived from the command fields only.
    function automatic exp_t expectedOf(input logic [1:0] fun, input logic [15:0] a, input logic [15:0] b);
        exp_t        e;
        logic [16:0] sum;
        logic [31:0] prod;
        e.carry   = 1'b0;
        e.err     = 1'b0;
        e.execCyc = 1;
        e.aEnCyc  = 1;
        e.data    = '0;
        case (fun)
            2'b00: begin
                sum     = {1'b0, a} + {1'b0, b};
                e.data  = sum[15:0];
                e.carry = sum[16];
            end
            2'b01: e.data = a - b;
            2'b10: begin
                prod      = {16'b0, a} * {16'b0, b};
                e.data    = prod[15:0];
                e.execCyc = MUL_CYC;
                e.aEnCyc  = MUL_CYC;
            end
            default: begin
                e.execCyc = DIV_CYC;
                e.aEnCyc  = DIV_CYC;
                if (b == '0) begin
                    e.data = '1;
`ifdef ARITH_CTRL_DIVZ_CHECK_EN
                    e.err     = 1'b1;
                    e.execCyc = 0;
                    e.aEnCyc  = 0;
`endif
                end else begin
                    e.data = a / b;
                end
            end
        endcase
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one command from a negedge, tracks EXEC timing, then drains the response after 'stall' cycles.
    task automatic applyStimulus(input logic [1:0] fun, input logic [15:0] a, input logic [15:0] b,
                                 input int stall, input bit holdNext);
        exp_t e;
        int   w;
        int   lat;
        int   aEnCnt;
        cmdValid = 1'b1;
        cmdFun   = fun;
        cmdOpA   = a;
        cmdOpB   = b;
        resReady = (stall == 0);
        w = 0;
        while (!cmdReady && w < 100) begin
            @(negedge clock);
            w++;
        end
        checkOutput("cmd_ready", 32'(cmdReady), 32'(1));
        sbQ.push_back(expectedOf(fun, a, b));
        @(negedge clock);
        if (holdNext) begin
            cmdFun = 2'b00;
            cmdOpA = 16'd1;
            cmdOpB = 16'd2;
        end else begin
            cmdValid = 1'b0;
        end
        lat    = 0;
        aEnCnt = 0;
        while (!resValid && lat < 100) begin
            aEnCnt += int'(aEn);
            if (holdNext) checkOutput("exec_no_accept", 32'(cmdReady), 32'(0));
            lat++;
            @(negedge clock);
        end
        checkOutput("res_valid", 32'(resValid), 32'(1));
        e = sbQ.pop_front();
        checkOutput("latency", 32'(lat), 32'(e.execCyc));
        checkOutput("a_en_cycles", 32'(aEnCnt), 32'(e.aEnCyc));
        checkOutput("res_data", 32'(resData), 32'(e.data));
        checkOutput("res_carry", 32'(resCarry), 32'(e.carry));
        checkOutput("res_err", 32'(resErr), 32'(e.err));
        checkOutput("busy_resp", 32'(busy), 32'(1));
        for (int i = 0; i < stall; i++) begin
            @(negedge clock);
            checkOutput("hold_valid", 32'(resValid), 32'(1));
            checkOutput("hold_data", 32'(resData), 32'(e.data));
            checkOutput("hold_ready", 32'(cmdReady), 32'(0));
        end
        resReady = 1'b1;
        @(negedge clock);
        checkOutput("release_valid", 32'(resValid), 32'(0));
        checkOutput("release_ready", 32'(cmdReady), 32'(1));
        resReady = 1'b0;
    endtask

    initial begin
        int          seenValid;
        logic [1:0]  rFun;
        logic [15:0] rA;
        logic [15:0] rB;
        resetN   = 1'b0;
        cmdValid = 1'b0;
        cmdFun   = '0;
        cmdOpA   = '0;
        cmdOpB   = '0;
        resReady = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checkOutput("rst_cmd_ready", 32'(cmdReady), 32'(1));
        checkOutput("rst_a_en", 32'(aEn), 32'(0));
        checkOutput("rst_res_valid", 32'(resValid), 32'(0));
        checkOutput("rst_busy", 32'(busy), 32'(0));
        checkOutput("rst_res_data", 32'(resData), 32'(0));
        checkOutput("rst_res_carry", 32'(resCarry), 32'(0));
        checkOutput("rst_res_err", 32'(resErr), 32'(0));
        resetN = 1'b1;
        @(negedge clock);

        applyStimulus(2'b00, 16'hFFFF, 16'h0002, 0, 1'b0);
        applyStimulus(2'b10, 16'h0100, 16'h0101, 1, 1'b0);
        applyStimulus(2'b01, 16'h0003, 16'h0005, 5, 1'b0);
        applyStimulus(2'b11, 16'd100, 16'd7, 0, 1'b1);
        applyStimulus(2'b00, 16'd1, 16'd2, 0, 1'b0);

`ifdef ARITH_CTRL_DIVZ_CHECK_EN
        applyStimulus(2'b11, 16'd5, 16'd0, 0, 1'b0);
        applyStimulus(2'b00, 16'd1, 16'd1, 0, 1'b0);
`endif

        // Reset in the middle of a divide must drop it without a late response.
        cmdValid = 1'b1;
        cmdFun   = 2'b11;
        cmdOpA   = 16'd200;
        cmdOpB   = 16'd3;
        @(negedge clock);
        cmdValid = 1'b0;
        @(negedge clock);
        checkOutput("mid_exec_a_en", 32'(aEn), 32'(1));
        resetN = 1'b0;
        @(negedge clock);
        checkOutput("midrst_a_en", 32'(aEn), 32'(0));
        checkOutput("midrst_res_valid", 32'(resValid), 32'(0));
        checkOutput("midrst_cmd_ready", 32'(cmdReady), 32'(1));
        checkOutput("midrst_res_data", 32'(resData), 32'(0));
        checkOutput("midrst_busy", 32'(busy), 32'(0));
        resetN = 1'b1;
        seenValid = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            seenValid += int'(resValid);
        end
        checkOutput("midrst_no_late_valid", 32'(seenValid), 32'(0));

        for (int i = 0; i < 10; i++) begin
            rFun = 2'($urandom_range(0, 3));
            rA   = 16'($urandom);
            rB   = 16'($urandom);
            if (rFun == 2'b11 && rB == '0) rB = 16'd1;
            applyStimulus(rFun, rA, rB, int'($urandom_range(0, 2)), 1'b0);
        end

        checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'(0));
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, %0d/%0d checks passed", passCnt, totalCnt);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
